// File: rtl/edisk_mapper.sv
// edisk_mapper: quasi-disk (E-disk) bank mapper for the Vector 06C core.
//   Latches the 8080 status word on the rising edge of SYNC and holds one
//   control register per fitted board, written by edge-detected OUT.
//   Resolves each memory access into a flat page number for the SDRAM mux.
//   Optional feature macro: EDISK_READBACK_EN (register readback via IN).
// Ports:
//   clk_sys      system clock
//   reset_n      asynchronous active-low reset
//   cpu_sync     CPU SYNC, status word valid on cpu_o while high
//   cpu_o[7:0]   CPU data out (status word or write data)
//   addr[15:0]   CPU address, port number on addr[7:0] for I/O
//   io_wr        I/O write strobe (level)
//   io_rd        I/O read strobe (level)
//   status_word  latched status word
//   ed_page[5:0] 0 = main RAM, else 1 + 4*board + page
//   ed_hit       ed_page != 0
//   io_sel       read of a fitted board port (readback builds only)
//   io_data      readback data, 8'hFF when io_sel = 0
module edisk_mapper #(
   parameter int         NUM_DISKS = 1,
   parameter logic [7:0] BASE_PORT = 8'h10
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        cpu_sync,
   input  logic [7:0]  cpu_o,
   input  logic [15:0] addr,
   input  logic        io_wr,
   input  logic        io_rd,
   output logic [7:0]  status_word,
   output logic [5:0]  ed_page,
   output logic        ed_hit,
   output logic        io_sel,
   output logic [7:0]  io_data
);
   logic [7:0] ctl [NUM_DISKS];
   logic io_wr_q, cpu_sync_q;
   logic [NUM_DISKS-1:0] port_hit, stk, wnd;
   logic [5:0] stk_pg [NUM_DISKS];
   logic [5:0] wnd_pg [NUM_DISKS];
   logic ram_read, io_read, io_write, io_stack, write_n, mem_acc, wr_edge;
   logic unused_bits;
   assign ram_read = status_word[7];
   assign io_read  = status_word[6];
   assign io_write = status_word[4];
   assign io_stack = status_word[2];
   assign write_n  = status_word[1];
   assign mem_acc  = (ram_read | ~write_n) & ~io_write & ~io_read;
   assign wr_edge  = io_wr & ~io_wr_q;
   assign unused_bits = ^{addr[12:8], io_rd};
   for (genvar n = 0; n < NUM_DISKS; n++) begin : g_board
      logic win;
      // 9-bit compare so ports past 8'hFF never wrap back onto low ports
      assign port_hit[n] = {1'b0, addr[7:0]} == ({1'b0, BASE_PORT} + 9'(n));
      // A000-DFFF always mapped; 8000-9FFF and E000-FFFF are optional
      assign win = addr[15] & ((addr[14] ^ addr[13]) |
                               (ctl[n][7] & addr[14] & addr[13]) |
                               (ctl[n][6] & ~addr[14] & ~addr[13]));
      assign stk[n]    = ctl[n][4] & io_stack & mem_acc;
      assign wnd[n]    = ctl[n][5] & win & mem_acc;
      assign stk_pg[n] = 6'(1 + 4 * n) + {4'b0, ctl[n][3:2]};
      assign wnd_pg[n] = 6'(1 + 4 * n) + {4'b0, ctl[n][1:0]};
   end
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         status_word <= '0;
         io_wr_q     <= 1'b0;
         cpu_sync_q  <= 1'b0;
         for (int n = 0; n < NUM_DISKS; n++) ctl[n] <= '0;
      end else begin
         io_wr_q    <= io_wr;
         cpu_sync_q <= cpu_sync;
         if (cpu_sync && !cpu_sync_q) status_word <= cpu_o;
         for (int n = 0; n < NUM_DISKS; n++)
            if (wr_edge && port_hit[n]) ctl[n] <= cpu_o;
      end
   end
   // Later assignments win: stack class overrides window, lowest board last
   always_comb begin
      ed_page = '0;
      for (int n = NUM_DISKS - 1; n >= 0; n--) if (wnd[n]) ed_page = wnd_pg[n];
      for (int n = NUM_DISKS - 1; n >= 0; n--) if (stk[n]) ed_page = stk_pg[n];
   end
   assign ed_hit = |ed_page;
`ifdef EDISK_READBACK_EN
   always_comb begin
      io_sel  = 1'b0;
      io_data = 8'hFF;
      for (int n = NUM_DISKS - 1; n >= 0; n--)
         if (io_read && io_rd && port_hit[n]) begin
            io_sel  = 1'b1;
            io_data = ctl[n];
         end
   end
`else
   assign io_sel  = 1'b0;
   assign io_data = 8'hFF;
`endif
endmodule

// File: tb/tb_edisk_mapper.sv
// tb_edisk_mapper: self-checking bench for edisk_mapper (1-board and 4-board instances)
module tb_edisk_mapper;
   logic clk_sys = 1'b0, reset_n = 1'b0, cpu_sync = 1'b0, io_wr = 1'b0, io_rd = 1'b0;
   logic [7:0]  cpu_o = '0;
   logic [15:0] addr = '0;
   logic [7:0] s1, s4, d1, d4;
   logic [5:0] p1, p4;
   logic h1, h4, sel1, sel4;
`ifdef EDISK_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif
   int checks = 0, failures = 0;
   logic [7:0] m1 [4];
   logic [7:0] m4 [4];
   logic [7:0] m_st;
   bit run = 1'b0;

   always #5 clk_sys = ~clk_sys;

   edisk_mapper #(.NUM_DISKS(1), .BASE_PORT(8'h10)) u1 (
      .clk_sys(clk_sys), .reset_n(reset_n), .cpu_sync(cpu_sync), .cpu_o(cpu_o),
      .addr(addr), .io_wr(io_wr), .io_rd(io_rd), .status_word(s1), .ed_page(p1),
      .ed_hit(h1), .io_sel(sel1), .io_data(d1));
   edisk_mapper #(.NUM_DISKS(4), .BASE_PORT(8'h10)) u4 (
      .clk_sys(clk_sys), .reset_n(reset_n), .cpu_sync(cpu_sync), .cpu_o(cpu_o),
      .addr(addr), .io_wr(io_wr), .io_rd(io_rd), .status_word(s4), .ed_page(p4),
      .ed_hit(h4), .io_sel(sel4), .io_data(d4));

   task automatic cmp(string name, logic [15:0] got, logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference mapping: classify the 8 KB segment, stack hits first, lowest board first
   function automatic logic [5:0] mpage(int nd, logic [7:0] r [4], logic [7:0] st, logic [15:0] a);
      bit mem, in_win;
      int seg;
      mem = (st[7] || !st[1]) && !st[4] && !st[6];
      seg = int'(a[15:13]);
      if (!mem) return 6'd0;
      for (int n = 0; n < nd; n++)
         if (st[2] && r[n][4]) return 6'(1 + 4 * n + int'(r[n][3:2]));
      for (int n = 0; n < nd; n++) begin
         in_win = seg == 5 || seg == 6 || (seg == 7 && r[n][7]) || (seg == 4 && r[n][6]);
         if (r[n][5] && in_win) return 6'(1 + 4 * n + int'(r[n][1:0]));
      end
      return 6'd0;
   endfunction

   always @(negedge clk_sys) if (run) begin
      logic [5:0] e1, e4;
      int port;
      bit r1, r4;
      e1 = mpage(1, m1, m_st, addr);
      e4 = mpage(4, m4, m_st, addr);
      port = int'(addr[7:0]);
      r1 = RB && m_st[6] && io_rd && port == 16;
      r4 = RB && m_st[6] && io_rd && port >= 16 && port < 20;
      cmp("u1_status", s1, m_st);
      cmp("u4_status", s4, m_st);
      cmp("u1_page", p1, e1);
      cmp("u4_page", p4, e4);
      cmp("u1_hit", h1, e1 != 0);
      cmp("u4_hit", h4, e4 != 0);
      cmp("u1_io_sel", sel1, r1);
      cmp("u4_io_sel", sel4, r4);
      cmp("u1_io_data", d1, r1 ? m1[0] : 8'hFF);
      cmp("u4_io_data", d4, r4 ? m4[port - 16] : 8'hFF);
   end

   task automatic tick;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic mreset;
      for (int i = 0; i < 4; i++) begin
         m1[i] = '0;
         m4[i] = '0;
      end
      m_st = '0;
   endtask

   task automatic mwr(logic [7:0] p, logic [7:0] d);
      if (p == 8'h10) m1[0] = d;
      if (p >= 8'h10 && p < 8'h14) m4[p - 8'h10] = d;
   endtask

   task automatic out_port(logic [7:0] p, logic [7:0] d);
      addr = {8'h00, p};
      cpu_o = d;
      io_wr = 1'b1;
      tick;
      mwr(p, d);
      io_wr = 1'b0;
      tick;
   endtask

   task automatic set_status(logic [7:0] s);
      cpu_o = s;
      cpu_sync = 1'b1;
      tick;
      m_st = s;
      cpu_sync = 1'b0;
      tick;
   endtask

   task automatic at(logic [15:0] a);
      addr = a;
      #1;
   endtask

   initial begin
      mreset;
      run = 1'b1;
      tick;
      tick;
      cmp("rst_status", s1, 8'h00);
      cmp("rst_page", p4, 6'd0);
      cmp("rst_io_data", d4, 8'hFF);
      reset_n = 1'b1;
      tick;
      // window mapping
      out_port(8'h10, 8'h22);
      set_status(8'h80);
      at(16'hA000); cmp("win_A000", p1, 6'd3); cmp("win_A000_u4", p4, 6'd3); tick;
      at(16'hC000); cmp("win_C000", p1, 6'd3); tick;
      at(16'h8000); cmp("win_8000_off", p1, 6'd0); tick;
      at(16'hE000); cmp("win_E000_off", p1, 6'd0); tick;
      out_port(8'h10, 8'hE2);
      at(16'h8000); cmp("win_8000_on", p1, 6'd3); tick;
      at(16'hE000); cmp("win_E000_on", p1, 6'd3); tick;
      at(16'h0000); cmp("win_0000", p1, 6'd0); tick;
      // stack priority
      out_port(8'h10, 8'h38);
      set_status(8'h84);
      at(16'h1234); cmp("stk_1234", p1, 6'd3); cmp("stk_hit", h1, 1'b1); tick;
      set_status(8'h80);
      at(16'hA000); cmp("stk_off_win", p1, 6'd1); tick;
      // reset mid-operation, with a write in flight
      out_port(8'h10, 8'h3F);
      at(16'hA000); cmp("pre_rst", p1, 6'd4); tick;
      addr = 16'h0010;
      cpu_o = 8'h22;
      io_wr = 1'b1;
      #1;
      reset_n = 1'b0;
      mreset;
      #1;
      cmp("mid_rst_status", s1, 8'h00);
      cmp("mid_rst_page", p1, 6'd0);
      cmp("mid_rst_io_sel", sel4, 1'b0);
      tick;
      tick;
      io_wr = 1'b0;
      tick;
      reset_n = 1'b1;
      tick;
      set_status(8'h80);
      at(16'hA000); cmp("post_rst_u1", p1, 6'd0); cmp("post_rst_u4", p4, 6'd0); tick;
      // multi-board
      out_port(8'h12, 8'h21);
      at(16'hA000); cmp("mb_board2", p4, 6'd10); cmp("mb_unfitted_u1", p1, 6'd0); tick;
      out_port(8'h11, 8'h23);
      at(16'hA000); cmp("mb_lowest", p4, 6'd8); cmp("mb_u1_11", p1, 6'd0); tick;
      out_port(8'h14, 8'hFF);
      at(16'hA000); cmp("mb_port14", p4, 6'd8); tick;
      // write edge detect
      addr = 16'h0010;
      cpu_o = 8'h21;
      io_wr = 1'b1;
      tick;
      mwr(8'h10, 8'h21);
      cpu_o = 8'h22;
      repeat (9) tick;
      io_wr = 1'b0;
      tick;
      at(16'hA000); cmp("edge_u1", p1, 6'd2); cmp("edge_u4", p4, 6'd2); tick;
      // status latch holds while SYNC stays high
      cpu_o = 8'h82;
      cpu_sync = 1'b1;
      tick;
      m_st = 8'h82;
      cpu_o = 8'h00;
      repeat (3) tick;
      cpu_sync = 1'b0;
      tick;
      cmp("sync_hold", s1, 8'h82);
      // simultaneous SYNC edge and write edge
      addr = 16'h0010;
      cpu_o = 8'hA4;
      cpu_sync = 1'b1;
      io_wr = 1'b1;
      tick;
      m_st = 8'hA4;
      mwr(8'h10, 8'hA4);
      cpu_sync = 1'b0;
      io_wr = 1'b0;
      tick;
      cmp("sim_status", s4, 8'hA4);
      at(16'hE000); cmp("sim_u1", p1, 6'd1); cmp("sim_u4", p4, 6'd1); tick;
      // readback
      out_port(8'h11, 8'h5A);
      set_status(8'h40);
      addr = 16'h0011;
      io_rd = 1'b1;
      #1;
      cmp("rb_sel", sel4, RB);
      cmp("rb_data", d4, RB ? 8'h5A : 8'hFF);
      cmp("rb_u1_sel", sel1, 1'b0);
      tick;
      at(16'h0018); cmp("rb_18_sel", sel4, 1'b0); cmp("rb_18_data", d4, 8'hFF); tick;
      io_rd = 1'b0;
      tick;
      run = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
